// File: rtl/cacheline_burst_adaptor.sv
// Line-to-burst adaptor between the cache arbiter and the burst DRAM port.
// Splits 256-bit line reads/writes into 4 x 64-bit beats and reassembles read lines.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   mem_address/read/write line request from arbiter (held until mem_resp)
//   mem_wdata / mem_rdata  whole-line write data in, assembled read line out
//   mem_resp               one-cycle line-complete pulse
//   pmem_address           line-aligned burst base address (registered)
//   pmem_read/pmem_write   burst command, exactly one high while bursting
//   pmem_wdata/pmem_rdata  current write beat out, current read beat in
//   pmem_resp              per-beat acknowledge from memory
module cacheline_burst_adaptor #(
    parameter int BEATS      = 4,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_WIDTH-1:0]       mem_address,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [BEATS*BEAT_WIDTH-1:0] mem_wdata,
    output logic [BEATS*BEAT_WIDTH-1:0] mem_rdata,
    output logic                        mem_resp,
    output logic [ADDR_WIDTH-1:0]       pmem_address,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic [BEAT_WIDTH-1:0]       pmem_wdata,
    input  logic [BEAT_WIDTH-1:0]       pmem_rdata,
    input  logic                        pmem_resp
);

    localparam int LW  = BEATS * BEAT_WIDTH;
    localparam int CW  = $clog2(BEATS);
    localparam int BSH = $clog2(BEAT_WIDTH);

    // Clears the byte-offset-within-line bits of the request address.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LW / 8 - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LW-1:0]         r_wline;
    logic [LW-1:0]         r_stage;
    logic [LW-1:0]         r_rdata;

    logic                  w_accept_wr;
    logic                  w_accept_rd;
    logic                  w_bursting;
    logic                  w_beat;
    logic                  w_last;
    logic [CW+BSH-1:0]     w_base;
    logic [LW-1:0]         w_stage_nxt;

    assign w_bursting = (r_state == RD_BURST) || (r_state == WR_BURST);
    assign w_beat     = w_bursting && pmem_resp;
    assign w_last     = (r_cnt == CW'(BEATS - 1));
    assign w_base     = {r_cnt, {BSH{1'b0}}};

    // Staging line with the incoming beat dropped into its slot.
    always_comb begin
        w_stage_nxt = r_stage;
        w_stage_nxt[w_base +: BEAT_WIDTH] = pmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept_wr = 1'b0;
        w_accept_rd = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Write has priority when both requests are raised.
                if (mem_write) begin
                    w_accept_wr = 1'b1;
                    w_state_nxt = WR_BURST;
                end else if (mem_read) begin
                    w_accept_rd = 1'b1;
                    w_state_nxt = RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (pmem_resp && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wline <= '0;
            r_stage <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept_wr || w_accept_rd) begin
                r_addr <= mem_address & ALIGN_MASK;
                r_cnt  <= '0;
            end
            if (w_accept_wr) begin
                r_wline <= mem_wdata;
            end
            if (w_beat) begin
                r_cnt <= r_cnt + CW'(1);
            end
            // Partial lines stay in r_stage; only a full line reaches r_rdata.
            if (w_beat && (r_state == RD_BURST)) begin
                r_stage <= w_stage_nxt;
                if (w_last) begin
                    r_rdata <= w_stage_nxt;
                end
            end
        end
    end

    assign mem_rdata    = r_rdata;
    assign mem_resp     = (r_state == DONE);
    assign pmem_address = r_addr;
    assign pmem_read    = (r_state == RD_BURST);
    assign pmem_write   = (r_state == WR_BURST);
    assign pmem_wdata   = (r_state == WR_BURST) ? r_wline[w_base +: BEAT_WIDTH]
                                                : '0;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor: vector table of line transactions
// with per-beat stall gaps, plus hand sequences for reset and mid-burst reset.
module tb_cacheline_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    cacheline_burst_adaptor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    typedef struct {
        bit             rd;
        bit             wr;
        logic [31:0]    addr;
        logic [255:0]   line;      // write data, or beats memory returns
        logic [3:0][3:0] gaps;     // stall cycles before beat i
        logic [31:0]    exp_paddr;
    } vec_t;

    int           checks   = 0;
    int           failures = 0;
    logic [255:0] prev_rd;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_pread"},  pmem_read,    0);
        chk({tag, "_pwrite"}, pmem_write,   0);
        chk({tag, "_paddr"},  pmem_address, 0);
        chk({tag, "_pwdata"}, pmem_wdata,   0);
        chk({tag, "_mresp"},  mem_resp,     0);
        chk({tag, "_mrdata"}, mem_rdata,    0);
    endtask

    task automatic run_txn(input vec_t v);
        int b;
        int gap;
        int cyc;
        int lat;
        logic [255:0] exp_rd;
        bit is_wr;
        is_wr  = v.wr;
        exp_rd = is_wr ? prev_rd : v.line;
        lat    = 5;
        for (int i = 0; i < 4; i++) lat += int'(v.gaps[i]);
        @(negedge clk);
        chk("idle_mresp", mem_resp, 0);
        chk("idle_cmd", {pmem_read, pmem_write}, 0);
        mem_read    = v.rd;
        mem_write   = v.wr;
        mem_address = v.addr;
        mem_wdata   = v.line;
        pmem_resp   = 1'b0;
        b   = 0;
        gap = int'(v.gaps[0]);
        cyc = 0;
        while (b < 4) begin
            @(negedge clk);
            cyc++;
            if (cyc > 60) begin
                chk("burst_timeout", cyc, lat);
                break;
            end
            chk("paddr", pmem_address, v.exp_paddr);
            chk("pread", pmem_read, !is_wr);
            chk("pwrite", pmem_write, is_wr);
            chk("mresp_busy", mem_resp, 0);
            chk("rdata_hold", mem_rdata, prev_rd);
            if (is_wr) chk("wbeat", pmem_wdata, v.line[64*b +: 64]);
            else       chk("wdata_idle", pmem_wdata, 0);
            // Requester scribbles on address/data mid-burst; must be ignored.
            mem_address = ~v.addr;
            mem_wdata   = ~v.line;
            if (gap > 0) begin
                pmem_resp  = 1'b0;
                pmem_rdata = {$urandom, $urandom};
                gap--;
            end else begin
                pmem_resp  = 1'b1;
                pmem_rdata = is_wr ? {$urandom, $urandom} : v.line[64*b +: 64];
                b++;
                if (b < 4) gap = int'(v.gaps[b]);
            end
        end
        @(negedge clk);
        cyc++;
        pmem_resp = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk("done_mresp", mem_resp, 1);
        chk("done_cmd", {pmem_read, pmem_write}, 0);
        chk("latency", cyc, lat);
        chk("line", mem_rdata, exp_rd);
        prev_rd = exp_rd;
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{1'b1, 1'b0, 32'h0000_1234,
                  {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                  16'h0000, 32'h0000_1220};
        vt[1] = '{1'b0, 1'b1, 32'h8000_0040,
                  {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                  16'h0000, 32'h8000_0040};
        vt[2] = '{1'b1, 1'b0, 32'h0000_ABCD,
                  {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   64'h0F1E_2D3C_4B5A_6978, 64'h8877_6655_4433_2211},
                  16'h2130, 32'h0000_ABC0};
        vt[3] = '{1'b1, 1'b1, 32'h1234_567F,
                  {64'h5555_0000_5555_0000, 64'h6666_1111_6666_1111,
                   64'h7777_2222_7777_2222, 64'h9999_3333_9999_3333},
                  16'h0102, 32'h1234_5660};
        vt[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF,
                  {64'hA5A5_A5A5_5A5A_5A5A, 64'h0000_0000_FFFF_FFFF,
                   64'hFFFF_FFFF_0000_0000, 64'h1357_9BDF_2468_ACE0},
                  16'h1000, 32'hFFFF_FFE0};
        vt[5] = '{1'b0, 1'b1, 32'h0000_001F,
                  {64'hCAFE_BABE_DEAD_BEEF, 64'h0BAD_F00D_1234_5678,
                   64'h8BAD_F00D_FEED_FACE, 64'h0000_0001_0000_0002},
                  16'h0000, 32'h0000_0000};

        rst_n       = 1'b0;
        mem_address = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wdata   = '0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;
        prev_rd     = '0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // Back-to-back: each vector is issued the cycle after the previous mem_resp.
        for (int i = 0; i < 6; i++) run_txn(vt[i]);

        // Reset after the second read beat abandons the burst.
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 32'h0000_2000;
        @(negedge clk);
        chk("mid_pread", pmem_read, 1);
        pmem_resp  = 1'b1;
        pmem_rdata = 64'hDEAD_0000_0000_0001;
        @(negedge clk);
        pmem_rdata = 64'hDEAD_0000_0000_0002;
        @(negedge clk);
        pmem_resp = 1'b0;
        mem_read  = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midrst");
        rst_n   = 1'b1;
        prev_rd = '0;
        run_txn('{1'b1, 1'b0, 32'h0000_2000,
                  {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                   64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101},
                  16'h0000, 32'h0000_2000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
